trap_load_sequencer: RTL and testbench
======================================

# trap_load_sequencer

Synchronous controller that drives the two inlet-valve control ports of a two-inlet cell-trap stage. It sequences inlet 1 and inlet 2 alternately into the shared node feeding the trap, with a programmable open time per inlet and a dead time between them. It also enforces break-before-make, so both valves are never open at once. The block sits directly upstream of the valve/trap netlist; its two valve outputs map one-to-one onto that stage's control ports.

## Interface
- CNT_W, 16, width of the duration counters and the duration inputs
- N_W, 8, width of the load-count input and the load index

- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a load run; sampled only when idle or in the done cycle
- abort  in  1  terminate the run and close both valves
- t1_len  in  CNT_W  inlet-1 open time in cycles; latched at start
- t2_len  in  CNT_W  inlet-2 open time in cycles; latched at start
- dead_len  in  CNT_W  closed time after each open phase; latched at start
- loads  in  N_W  number of inlet-1/inlet-2 load pairs; latched at start
- valve1_open  out  1  drives control port of inlet-1 valve; 1 = open
- valve2_open  out  1  drives control port of inlet-2 valve; 1 = open
- busy  out  1  run in progress
- done  out  1  one-cycle pulse on normal completion
- load_idx  out  N_W  index of the current load pair (0-based)

## Operation
- States: IDLE, OPEN1, GAP1, OPEN2, GAP2, DONE. A single down-counter times each phase.
- IDLE:
  - start=1 and abort=0 latches t1_len, t2_len, dead_len and loads, and clears load_idx.
  - If the latched loads = 0, go to DONE. Otherwise go to OPEN1.
- Phase durations: each phase lasts max(len,1) cycles. A length of 0 is treated as 1, so the dead gap is always ≥1 cycle.
- Phase order: OPEN1 → GAP1 → OPEN2 → GAP2.
- End of GAP2:
  - If load_idx = loads−1, go to DONE.
  - Otherwise increment load_idx and go to OPEN1.
- DONE lasts one cycle with done=1.
  - start=1 in DONE begins a new run, as in IDLE.
  - Otherwise go to IDLE.
- Outputs are registered and decoded from state:
  - valve1_open = (state==OPEN1)
  - valve2_open = (state==OPEN2)
  - busy = (state ∈ OPEN1, GAP1, OPEN2, GAP2)
  - done = (state==DONE)
- Invariant: valve1_open & valve2_open is never 1.
- abort=1 in any busy state: next state IDLE, no done pulse, both valves 0 from the next cycle. load_idx holds its value.
- abort and start both 1 in IDLE or DONE: abort wins, and the next state is IDLE.
- start while busy is ignored. Input changes while busy have no effect, because all lengths were latched at start.

## Timing
- Reset (asynchronous, immediate): state IDLE; valve1_open=0, valve2_open=0, busy=0, done=0, load_idx=0; counter cleared.
- Start is accepted at edge E0. From the cycle after E0:
  - valve1_open=1 for T1 = max(t1_len,1) cycles
  - both valves 0 for D = max(dead_len,1) cycles
  - valve2_open=1 for T2 = max(t2_len,1) cycles
  - both valves 0 for D cycles
- One load pair therefore takes T1+T2+2D cycles. done rises in the cycle after the final GAP2.
- Total latency from E0 to done = loads·(T1+T2+2D)+1 cycles. With loads=0, done asserts in the cycle after E0.
- load_idx updates on the same edge as the GAP2→OPEN1 transition.
- Reset asserted mid-run closes both valves asynchronously, with no done pulse.

## Test plan
- Single pair: t1=3, dead=2, t2=4, loads=1, start at E0. Required (cycles counted after E0):
  - valve1_open in cycles 1–3, valve2_open in cycles 6–9
  - busy in cycles 1–11; done in cycle 12 only
- Two loads, same lengths:
  - valve1_open in cycles 1–3 and 12–14
  - load_idx steps 0→1 at cycle 12
  - done in cycle 23; never both valves high
- Zero lengths: t1=t2=dead=0, loads=3.
  - Required pattern per pair: valve1 1 cycle, gap 1, valve2 1 cycle, gap 1.
  - done in cycle 13.
  - loads=0: done in cycle 1, no valve opens.
- Abort in cycle 7 of the single-pair run:
  - valve2_open=0 from cycle 8, busy=0 from cycle 8, done never asserts.
  - Subsequent start runs normally.
- Start in done cycle and start while busy:
  - Start in cycle 12 (the done cycle) of the single-pair run yields valve1_open in cycles 13–15.
  - Start pulses during busy are ignored.
  - start+abort together in idle keeps the block idle.
- Asynchronous reset mid-OPEN1 (between edges):
  - All outputs 0 immediately, load_idx=0.
  - After release, start yields the nominal sequence.

Source files
------------

// File: rtl/trap_load_sequencer.sv
// Alternating two-inlet valve sequencer for a cell-trap stage: OPEN1, dead gap,
// OPEN2, dead gap per load pair, with break-before-make between the two valves.
module trap_load_sequencer #(
  parameter int CNT_W = 16,
  parameter int N_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t1_len,
  input  logic [CNT_W-1:0] t2_len,
  input  logic [CNT_W-1:0] dead_len,
  input  logic [N_W-1:0]   loads,
  output logic             valve1_open,
  output logic             valve2_open,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   load_idx,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN1 = 3'd1,
    GAP1  = 3'd2,
    OPEN2 = 3'd3,
    GAP2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [N_W-1:0]   idx_nxt;
  logic [CNT_W-1:0] t1_q;
  logic [CNT_W-1:0] t2_q;
  logic [CNT_W-1:0] dead_q;
  logic [N_W-1:0]   loads_q;
  logic             latch_cfg;
  logic             in_run;
  logic             last_pair;

  assign state_dbg = state;

  // Counter is loaded with duration-1 so a phase ends when it reads zero;
  // a zero length still yields one cycle.
  function automatic logic [CNT_W-1:0] phase_cnt(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign in_run    = (state == OPEN1) || (state == GAP1) ||
                     (state == OPEN2) || (state == GAP2);
  assign last_pair = (load_idx == loads_q - N_W'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = load_idx;
    latch_cfg = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        if (start && !abort) begin
          latch_cfg = 1'b1;
          idx_nxt   = '0;
          if (loads == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = OPEN1;
            cnt_nxt   = phase_cnt(t1_len);
          end
        end
      end
      OPEN1: begin
        if (cnt == '0) begin
          state_nxt = GAP1;
          cnt_nxt   = phase_cnt(dead_q);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP1: begin
        if (cnt == '0) begin
          state_nxt = OPEN2;
          cnt_nxt   = phase_cnt(t2_q);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      OPEN2: begin
        if (cnt == '0) begin
          state_nxt = GAP2;
          cnt_nxt   = phase_cnt(dead_q);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP2: begin
        if (cnt == '0) begin
          if (last_pair) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = OPEN1;
            cnt_nxt   = phase_cnt(t1_q);
            idx_nxt   = load_idx + N_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Abort drops the run without a done pulse; load_idx keeps its last value.
    if (abort && in_run) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = load_idx;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      load_idx    <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      dead_q      <= '0;
      loads_q     <= '0;
      valve1_open <= 1'b0;
      valve2_open <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      load_idx <= idx_nxt;
      if (latch_cfg) begin
        t1_q    <= t1_len;
        t2_q    <= t2_len;
        dead_q  <= dead_len;
        loads_q <= loads;
      end
      valve1_open <= (state_nxt == OPEN1);
      valve2_open <= (state_nxt == OPEN2);
      busy        <= (state_nxt == OPEN1) || (state_nxt == GAP1) ||
                     (state_nxt == OPEN2) || (state_nxt == GAP2);
      done        <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_trap_load_sequencer.sv
// Table-driven bench for trap_load_sequencer: one row per clock cycle with the
// outputs expected after that edge, plus hand-written reset sequences.
module tb_trap_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] t1_len = '0;
  logic [15:0] t2_len = '0;
  logic [15:0] dead_len = '0;
  logic [7:0]  loads = '0;
  logic        valve1_open;
  logic        valve2_open;
  logic        busy;
  logic        done;
  logic [7:0]  load_idx;
  logic [2:0]  state_dbg;

  trap_load_sequencer #(.CNT_W(16), .N_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .t1_len(t1_len), .t2_len(t2_len), .dead_len(dead_len), .loads(loads),
    .valve1_open(valve1_open), .valve2_open(valve2_open), .busy(busy),
    .done(done), .load_idx(load_idx), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        abort;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [15:0] dead;
    logic [7:0]  loads;
    logic [11:0] exp;  // {valve1, valve2, busy, done, load_idx}
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cfg_t1, cfg_t2, cfg_dead, cfg_loads;
  int   rt1, rt2, rd;

  function automatic logic [11:0] outs();
    return {valve1_open, valve2_open, busy, done, load_idx};
  endfunction

  task automatic add(input int n, input bit st, input bit ab, input bit v1,
                     input bit v2, input bit b, input bit d, input int idx);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.start = st;
      v.abort = ab;
      v.t1    = 16'(cfg_t1);
      v.t2    = 16'(cfg_t2);
      v.dead  = 16'(cfg_dead);
      v.loads = 8'(cfg_loads);
      v.exp   = {v1, v2, b, d, 8'(idx)};
      vecs.push_back(v);
    end
  endtask

  // Durations seen by a run: max(len,1) of the values present at start.
  task automatic latch_run();
    rt1 = (cfg_t1 == 0) ? 1 : cfg_t1;
    rt2 = (cfg_t2 == 0) ? 1 : cfg_t2;
    rd  = (cfg_dead == 0) ? 1 : cfg_dead;
  endtask

  task automatic add_pair(input int idx, input bit st_first, input bit st_rest);
    add(1, st_first, 0, 1, 0, 1, 0, idx);
    add(rt1 - 1, st_rest, 0, 1, 0, 1, 0, idx);
    add(rd, st_rest, 0, 0, 0, 1, 0, idx);
    add(rt2, st_rest, 0, 0, 1, 1, 0, idx);
    add(rd, st_rest, 0, 0, 0, 1, 0, idx);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got v1v2/busy/done/idx=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
               name, got[11], got[10], got[9], got[8], got[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      start    = vecs[i].start;
      abort    = vecs[i].abort;
      t1_len   = vecs[i].t1;
      t2_len   = vecs[i].t2;
      dead_len = vecs[i].dead;
      loads    = vecs[i].loads;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), outs(), vecs[i].exp);
      if (valve1_open && valve2_open) begin
        n_bad++;
        $display("FAIL overlap row%0d: both valves open, required at most one", i);
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic single_run();
    cfg_t1 = 3; cfg_t2 = 4; cfg_dead = 2; cfg_loads = 1;
    latch_run();
    add_pair(0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int mid;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single pair: v1 cycles 1-3, v2 6-9, busy 1-11, done 12.
    single_run();
    // Two loads; start held and inputs scrambled during the second pair.
    cfg_loads = 2;
    latch_run();
    add_pair(0, 1, 0);
    cfg_t1 = 9; cfg_t2 = 1; cfg_dead = 7; cfg_loads = 5;
    add_pair(1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    // Zero lengths, three loads: done in cycle 13.
    cfg_t1 = 0; cfg_t2 = 0; cfg_dead = 0; cfg_loads = 3;
    latch_run();
    add_pair(0, 1, 0);
    add_pair(1, 0, 0);
    add_pair(2, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 2);
    add(1, 0, 0, 0, 0, 0, 0, 2);
    // loads=0: done in cycle 1, load_idx cleared.
    cfg_loads = 0;
    add(1, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // Abort in cycle 7 of a single-pair run, then a normal run.
    cfg_t1 = 3; cfg_t2 = 4; cfg_dead = 2; cfg_loads = 1;
    add(1, 1, 0, 1, 0, 1, 0, 0);
    add(2, 0, 0, 1, 0, 1, 0, 0);
    add(2, 0, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0, 0);
    single_run();
    // Abort during the second pair keeps load_idx at 1.
    cfg_loads = 2;
    latch_run();
    add_pair(0, 1, 0);
    add(1, 0, 0, 1, 0, 1, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0, 0, 1);
    // Restart in the done cycle, then start+abort in done and in idle.
    cfg_loads = 1;
    latch_run();
    add_pair(0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add_pair(0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    mid = vecs.size();
    single_run();

    // Reset state, checked while reset is held.
    #12;
    check("reset_hold", outs(), 12'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_release", outs(), 12'h000);

    apply(0, mid);

    // Asynchronous reset mid-OPEN1 of the second pair.
    @(negedge clk);
    t1_len = 16'd3; t2_len = 16'd4; dead_len = 16'd2; loads = 8'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("pre_reset_open1", outs(), {1'b1, 1'b0, 1'b1, 1'b0, 8'd1});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 12'h000);
    @(negedge clk);
    rst = 1'b0;

    apply(mid, vecs.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
